// File: rtl/ws2812_driver.sv
// WS2812 single-wire serialiser: latches one {G,R,B} colour on start and sends 24 bits
// MSB first, then holds the line low for the latch gap before pulsing done.
module ws2812_driver #(
  parameter int unsigned T0H     = 8,
  parameter int unsigned T1H     = 16,
  parameter int unsigned T_BIT   = 25,
  parameter int unsigned T_LATCH = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  localparam int unsigned TMax = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0] BitLast   = TW'(T_BIT - 1);
  localparam logic [TW-1:0] LatchLast = TW'(T_LATCH - 1);
  localparam logic [TW-1:0] High0     = TW'(T0H);
  localparam logic [TW-1:0] High1     = TW'(T1H);

  typedef enum logic [1:0] {StIdle, StBit, StLatch} state_e;

  state_e        state_q;
  logic [23:0]   shift_q;
  logic [4:0]    cnt_q;
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic          done_q;
  logic          dout_q;

  logic [TW-1:0] timer_inc;
  logic [TW-1:0] high_cur;

  assign timer_inc = timer_q + 1'b1;
  assign high_cur  = shift_q[23] ? High1 : High0;

  // dout is registered, so each edge loads the level belonging to the next timer value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          dout_q <= 1'b0;
          if (start) begin
            shift_q <= {green, red, blue};
            cnt_q   <= 5'd23;
            timer_q <= '0;
            state_q <= StBit;
            busy_q  <= 1'b1;
            dout_q  <= 1'b1;
          end
        end
        StBit: begin
          busy_q <= 1'b1;
          if (timer_q == BitLast) begin
            timer_q <= '0;
            if (cnt_q == 5'd0) begin
              state_q <= StLatch;
              dout_q  <= 1'b0;
            end else begin
              shift_q <= {shift_q[22:0], 1'b0};
              cnt_q   <= cnt_q - 5'd1;
              dout_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_inc;
            dout_q  <= (timer_inc < high_cur);
          end
        end
        StLatch: begin
          dout_q <= 1'b0;
          if (timer_q == LatchLast) begin
            state_q <= StIdle;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b1;
            timer_q <= timer_inc;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Directed bench for ws2812_driver: logs dout/busy/done per cycle relative to the start
// edge and compares bit high times, latch gap and done timing with hand-computed values.
module tb_ws2812_driver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       busy;
  logic       done;
  logic       dout;

  int errors = 0;
  int checks = 0;

  localparam int LogLen = 3400;
  logic dout_l [LogLen];
  logic busy_l [LogLen];
  logic done_l [LogLen];
  int   exp_hi [24];

  ws2812_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .red   (red),
    .green (green),
    .blue  (blue),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sel: 0 = dout, 1 = busy, 2 = done; counts ones over cycles lo..hi inclusive.
  function automatic int count_l(input int sel, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) begin
      if (sel == 0 && dout_l[i]) n++;
      if (sel == 1 && busy_l[i]) n++;
      if (sel == 2 && done_l[i]) n++;
    end
    return n;
  endfunction

  // Start a frame at the next edge (cycle 0) and log cycles 1..n.
  task automatic capture(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int n, input bit hold, input int p1, input int p2,
                         input int gchg, input int rstc);
    for (int i = 0; i < LogLen; i++) begin
      dout_l[i] = 1'b0;
      busy_l[i] = 1'b0;
      done_l[i] = 1'b0;
    end
    red   = r;
    green = g;
    blue  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= n; c++) begin
      start = hold || (c == p1) || (c == p2);
      if (c == p1 || c == p2) begin
        red   = 8'h12;
        green = 8'h34;
        blue  = 8'h56;
      end
      if (c == gchg) green = 8'h00;
      if (rstc != 0 && c == rstc) rst_n = 1'b0;
      if (rstc != 0 && c == rstc + 4) rst_n = 1'b1;
      @(negedge clk);
      dout_l[c] = dout;
      busy_l[c] = busy;
      done_l[c] = done;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic check_bits(input int base);
    for (int n = 0; n < 24; n++) begin
      int p = base + 1 + 25 * n;
      int run = 0;
      while (run < 25 && dout_l[p + run]) run++;
      check($sformatf("hi_run_b%0d@%0d", n, base), run, exp_hi[n]);
      check($sformatf("hi_ones_b%0d@%0d", n, base), count_l(0, p, p + 24), exp_hi[n]);
    end
  endtask

  task automatic check_latch(input int base);
    check("latch_low", count_l(0, base + 601, base + 1600), 0);
    check("busy_span", count_l(1, base + 1, base + 1600), 1600);
    check("busy_end", int'(busy_l[base + 1601]), 0);
    check("done_cycle", int'(done_l[base + 1601]), 1);
    check("done_early", count_l(2, base + 1, base + 1600), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    red   = 8'h00;
    green = 8'h00;
    blue  = 8'h00;

    // Reset, then idle
    repeat (5) @(posedge clk);
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    begin
      int hi = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (dout || busy || done) hi++;
      end
      check("idle_quiet", hi, 0);
    end
    @(posedge clk);
    #1;

    // Colour encode: G=00 R=FF B=A5
    exp_hi = '{8, 8, 8, 8, 8, 8, 8, 8, 16, 16, 16, 16, 16, 16, 16, 16,
               16, 8, 16, 8, 8, 16, 8, 16};
    capture(8'hFF, 8'h00, 8'hA5, 1700, 1'b0, 0, 0, 0, 0);
    check_bits(0);
    check_latch(0);
    check("enc_done_cnt", count_l(2, 1, 1700), 1);

    // Start pulses while busy with a different colour are ignored
    capture(8'hFF, 8'h00, 8'hA5, 1700, 1'b0, 300, 1200, 0, 0);
    check_bits(0);
    check_latch(0);
    check("ign_done_cnt", count_l(2, 1, 1700), 1);
    check("ign_no_queue", count_l(1, 1602, 1700), 0);

    // Back-to-back with start held high, all channels 0x01
    exp_hi = '{8, 8, 8, 8, 8, 8, 8, 16, 8, 8, 8, 8, 8, 8, 8, 16,
               8, 8, 8, 8, 8, 8, 8, 16};
    capture(8'h01, 8'h01, 8'h01, 3300, 1'b1, 0, 0, 0, 0);
    check_bits(0);
    check_latch(0);
    check_bits(1601);
    check_latch(1601);
    check("b2b_gap", int'(dout_l[1601]), 0);
    check("b2b_rise", int'(dout_l[1602]), 1);
    check("b2b_busy2", int'(busy_l[1602]), 1);
    check("b2b_done_cnt", count_l(2, 1, 3300), 2);
    begin
      int k = 0;
      while (busy && k < 2000) begin
        @(posedge clk);
        #1;
        k++;
      end
      check("b2b_drain", int'(busy), 0);
    end
    @(posedge clk);
    #1;

    // Input stability: green 0x80 -> 0x00 at cycle 5 must not affect bit 0
    exp_hi = '{16, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8,
               8, 8, 8, 8, 8, 8, 8, 8};
    capture(8'h00, 8'h80, 8'h00, 1700, 1'b0, 0, 0, 5, 0);
    check_bits(0);
    check_latch(0);

    // Reset mid-frame at cycle 312 aborts silently
    capture(8'hFF, 8'h00, 8'hA5, 1700, 1'b0, 0, 0, 0, 312);
    check("abort_pre_dout", int'(dout_l[311]), 1);
    check("abort_dout", int'(dout_l[312]), 0);
    check("abort_busy", int'(busy_l[312]), 0);
    check("abort_no_done", count_l(2, 1, 1700), 0);
    check("abort_idle", count_l(1, 313, 1700), 0);
    check("abort_line", count_l(0, 313, 1700), 0);

    // Fresh frame after the abort
    exp_hi = '{8, 8, 8, 8, 8, 8, 8, 8, 16, 16, 16, 16, 16, 16, 16, 16,
               16, 8, 16, 8, 8, 16, 8, 16};
    capture(8'hFF, 8'h00, 8'hA5, 1700, 1'b0, 0, 0, 0, 0);
    check_bits(0);
    check_latch(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
